apb4_req_arbiter: RTL and testbench
===================================

Name: apb4_req_arbiter

Overview:
- Round-robin arbiter and APB4 master sequencer: shares one APB4 bus between NUM_REQ requester ports and drives it toward the APB slave.
- Accepts one transaction at a time from a request/ready port, runs the APB SETUP/ACCESS protocol, and returns read data and error status to the granted requester.
- Sits between requester blocks (or bench agents) and the APB slave under test.

Parameters:
- NUM_REQ, 4, number of requester ports (2..8)
- ADDR_WIDTH, 32, PADDR width
- DATA_WIDTH, 32, PWDATA/PRDATA width (multiple of 8)
- TIMEOUT_CYCLES, 16, ACCESS-phase wait-state limit (used only with APB_TIMEOUT_EN)

Ports:
- PCLK  in  1  clock; all logic rising-edge
- PRESETn  in  1  synchronous active-low reset
- req_valid  in  NUM_REQ  per-requester transaction request
- req_ready  out  NUM_REQ  one-hot accept strobe
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i in slice i
- req_write  in  NUM_REQ  1=write, 0=read
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
- req_strb  in  NUM_REQ*(DATA_WIDTH/8)  packed byte strobes
- req_prot  in  NUM_REQ*3  packed PPROT
- rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid
- rsp_err  out  1  error flag, valid with rsp_valid
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PADDR  out  ADDR_WIDTH  APB address
- PWRITE  out  1  APB direction
- PWDATA  out  DATA_WIDTH  APB write data
- PSTRB  out  DATA_WIDTH/8  APB strobes
- PPROT  out  3  APB protection
- PRDATA  in  DATA_WIDTH  slave read data
- PREADY  in  1  slave ready
- PSLVERR  in  1  slave error

Behaviour:
- Reset:
  - All outputs are 0, state is IDLE, and rr_ptr (last grant) is NUM_REQ-1, so requester 0 wins first.
  - Reset is synchronous and applies at any state. A transfer in flight is abandoned: PSEL/PENABLE drop at the next edge and no rsp_valid is issued.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any req_valid is set, grant g = first set bit scanning from rr_ptr+1 modulo NUM_REQ.
  - req_ready[g]=1 combinationally in IDLE only; it is the only ready bit set.
  - On that edge: latch addr/write/wdata/strb/prot of g, set rr_ptr=g, go to SETUP.
  - No req_valid: stay in IDLE, all outputs hold.
- SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA/PSTRB/PPROT from the latched values; unconditionally go to ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1, all address/control/data stable.
  - PREADY=0: stay in ACCESS (wait state).
  - PREADY=1: pulse rsp_valid[g] for 1 cycle on the next cycle, with rsp_rdata=PRDATA for reads (0 for writes) and rsp_err=PSLVERR. Drop PSEL/PENABLE and go to IDLE.
- APB outputs are registered. PADDR/PWRITE/PWDATA/PPROT keep their last values after completion. PSTRB is forced to 0 on reads.
- Latency:
  - req accept to PSEL: 1 cycle.
  - Minimum transfer, PREADY=1 in the first ACCESS cycle: accept at edge N, SETUP in N+1, ACCESS in N+2, rsp_valid in N+3.
  - A new grant is possible in the cycle rsp_valid is high (state is IDLE).
- Requester rules:
  - Fields stay stable while req_valid is high and req_ready is low.
  - req_valid may drop before grant without effect.
  - Requests arriving during SETUP/ACCESS wait; no req_ready is issued outside IDLE.
- Fairness: a requester holding req_valid is granted within NUM_REQ transfers.
- PREADY/PSLVERR/PRDATA are ignored outside ACCESS.

Optional Feature:
- APB_TIMEOUT_EN defined:
  - A wait counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - On reaching TIMEOUT_CYCLES, force completion: rsp_valid[g]=1, rsp_err=1, rsp_rdata=0, drop PSEL/PENABLE, go to IDLE.
  - A late PREADY is ignored.
- Undefined: no counter and no timeout logic; ACCESS waits indefinitely for PREADY.

Test Plan:
- Reset, then req_valid[0] write addr 0x10 data 0xA5A5A5A5 strb 0xF, PREADY tied 1 -> PSEL in cycle +1, PENABLE cycle +2, rsp_valid=0001 cycle +3, rsp_err=0.
- req_valid[2] read addr 0x20, PREADY low 2 ACCESS cycles, PRDATA=0x12345678 -> ACCESS lasts 3 cycles, PADDR stable, PSTRB=0, rsp_rdata=0x12345678 with rsp_valid=0100.
- All four req_valid held high -> grant order 0,1,2,3,0; each req_ready one-hot and only in IDLE.
- Write with PSLVERR=1 alongside PREADY=1 -> rsp_err=1 with rsp_valid.
- PRESETn low for 1 cycle during ACCESS -> next cycle PSEL=0, PENABLE=0, no rsp_valid, rr_ptr reset so requester 0 is granted first again.
- With APB_TIMEOUT_EN, TIMEOUT_CYCLES=16, PREADY held 0 -> exactly 16 ACCESS cycles, then rsp_valid with rsp_err=1 and rsp_rdata=0.

Source files
------------

// File: rtl/apb4_req_arbiter.sv
// apb4_req_arbiter: round-robin arbiter that shares one APB4 master port
// between NUM_REQ requesters. A grant is made only in IDLE; the transfer then
// walks SETUP -> ACCESS, and a one-cycle rsp_valid pulse returns the result.
// Optional: define APB_TIMEOUT_EN to bound ACCESS wait states to
// TIMEOUT_CYCLES, after which the transfer completes with rsp_err=1.
module apb4_req_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                               PCLK,
   input  logic                               PRESETn,
   input  logic [NUM_REQ-1:0]                 req_valid,
   output logic [NUM_REQ-1:0]                 req_ready,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]      req_addr,
   input  logic [NUM_REQ-1:0]                 req_write,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_wdata,
   input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]  req_strb,
   input  logic [NUM_REQ*3-1:0]               req_prot,
   output logic [NUM_REQ-1:0]                 rsp_valid,
   output logic [DATA_WIDTH-1:0]              rsp_rdata,
   output logic                               rsp_err,
   output logic                               PSEL,
   output logic                               PENABLE,
   output logic [ADDR_WIDTH-1:0]              PADDR,
   output logic                               PWRITE,
   output logic [DATA_WIDTH-1:0]              PWDATA,
   output logic [DATA_WIDTH/8-1:0]            PSTRB,
   output logic [2:0]                         PPROT,
   input  logic [DATA_WIDTH-1:0]              PRDATA,
   input  logic                               PREADY,
   input  logic                               PSLVERR
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t                  state_reg, state_next;
   logic [PTR_W-1:0]        rr_ptr_reg, rr_ptr_next;
   logic [PTR_W-1:0]        grant_reg, grant_next;
   logic                    psel_reg, psel_next;
   logic                    penable_reg, penable_next;
   logic [ADDR_WIDTH-1:0]   paddr_reg, paddr_next;
   logic                    pwrite_reg, pwrite_next;
   logic [DATA_WIDTH-1:0]   pwdata_reg, pwdata_next;
   logic [STRB_W-1:0]       pstrb_reg, pstrb_next;
   logic [2:0]              pprot_reg, pprot_next;
   logic [NUM_REQ-1:0]      rsp_valid_reg, rsp_valid_next;
   logic [DATA_WIDTH-1:0]   rsp_rdata_reg, rsp_rdata_next;
   logic                    rsp_err_reg, rsp_err_next;

`ifdef APB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]        wait_cnt_reg, wait_cnt_next;
`endif

   // Parameter sanity marker: an out-of-range configuration elaborates this
   // scope, which makes the mistake visible in the hierarchy.
   if (NUM_REQ < 2 || NUM_REQ > 8 || (DATA_WIDTH % 8) != 0 || TIMEOUT_CYCLES < 1) begin : g_invalid_params
   end

   // Per-requester views of the packed request fields.
   logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_REQ];
   logic [DATA_WIDTH-1:0]   wdata_arr [NUM_REQ];
   logic [STRB_W-1:0]       strb_arr  [NUM_REQ];
   logic [2:0]              prot_arr  [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
         assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
         assign strb_arr[gi]  = req_strb[gi*STRB_W +: STRB_W];
         assign prot_arr[gi]  = req_prot[gi*3 +: 3];
      end
   endgenerate

   logic                    grant_any;
   logic [PTR_W-1:0]        grant_idx;
   int                      scan_idx;
   logic [PTR_W-1:0]        scan_ptr;

   // Round-robin search: first valid requester after the last grant, wrapping.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      scan_idx  = 0;
      scan_ptr  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         scan_idx = int'(rr_ptr_reg) + k;
         if (scan_idx >= NUM_REQ)
            scan_idx = scan_idx - NUM_REQ;
         scan_ptr = PTR_W'(scan_idx);
         if (!grant_any && req_valid[scan_ptr]) begin
            grant_any = 1'b1;
            grant_idx = scan_ptr;
         end
      end
   end

   // Accept strobe: only in IDLE, only to the winner, and never during reset.
   always_comb begin
      req_ready = '0;
      if (PRESETn && state_reg == IDLE && grant_any)
         req_ready[grant_idx] = 1'b1;
   end

   // Next-state and next-output logic for the SETUP/ACCESS sequencer.
   always_comb begin
      state_next     = state_reg;
      rr_ptr_next    = rr_ptr_reg;
      grant_next     = grant_reg;
      psel_next      = psel_reg;
      penable_next   = penable_reg;
      paddr_next     = paddr_reg;
      pwrite_next    = pwrite_reg;
      pwdata_next    = pwdata_reg;
      pstrb_next     = pstrb_reg;
      pprot_next     = pprot_reg;
      rsp_valid_next = '0;
      rsp_rdata_next = rsp_rdata_reg;
      rsp_err_next   = rsp_err_reg;
`ifdef APB_TIMEOUT_EN
      wait_cnt_next  = wait_cnt_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (grant_any) begin
               rr_ptr_next = grant_idx;
               grant_next  = grant_idx;
               paddr_next  = addr_arr[grant_idx];
               pwrite_next = req_write[grant_idx];
               pwdata_next = wdata_arr[grant_idx];
               // Reads never carry strobes on the bus.
               pstrb_next  = req_write[grant_idx] ? strb_arr[grant_idx] : '0;
               pprot_next  = prot_arr[grant_idx];
               psel_next   = 1'b1;
               state_next  = SETUP;
            end
         end
         SETUP: begin
            penable_next = 1'b1;
            state_next   = ACCESS;
`ifdef APB_TIMEOUT_EN
            wait_cnt_next = '0;
`endif
         end
         ACCESS: begin
            if (PREADY) begin
               rsp_valid_next[grant_reg] = 1'b1;
               rsp_rdata_next = pwrite_reg ? '0 : PRDATA;
               rsp_err_next   = PSLVERR;
               psel_next      = 1'b0;
               penable_next   = 1'b0;
               state_next     = IDLE;
            end
`ifdef APB_TIMEOUT_EN
            else if (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               // Slave stalled too long: complete with an error and no data.
               rsp_valid_next[grant_reg] = 1'b1;
               rsp_rdata_next = '0;
               rsp_err_next   = 1'b1;
               psel_next      = 1'b0;
               penable_next   = 1'b0;
               state_next     = IDLE;
            end else begin
               wait_cnt_next = wait_cnt_reg + 1'b1;
            end
`endif
         end
         default: state_next = IDLE;
      endcase
   end

   // State and registered outputs; reset abandons any transfer in flight.
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state_reg     <= IDLE;
         rr_ptr_reg    <= PTR_W'(NUM_REQ - 1);
         grant_reg     <= '0;
         psel_reg      <= 1'b0;
         penable_reg   <= 1'b0;
         paddr_reg     <= '0;
         pwrite_reg    <= 1'b0;
         pwdata_reg    <= '0;
         pstrb_reg     <= '0;
         pprot_reg     <= '0;
         rsp_valid_reg <= '0;
         rsp_rdata_reg <= '0;
         rsp_err_reg   <= 1'b0;
`ifdef APB_TIMEOUT_EN
         wait_cnt_reg  <= '0;
`endif
      end else begin
         state_reg     <= state_next;
         rr_ptr_reg    <= rr_ptr_next;
         grant_reg     <= grant_next;
         psel_reg      <= psel_next;
         penable_reg   <= penable_next;
         paddr_reg     <= paddr_next;
         pwrite_reg    <= pwrite_next;
         pwdata_reg    <= pwdata_next;
         pstrb_reg     <= pstrb_next;
         pprot_reg     <= pprot_next;
         rsp_valid_reg <= rsp_valid_next;
         rsp_rdata_reg <= rsp_rdata_next;
         rsp_err_reg   <= rsp_err_next;
`ifdef APB_TIMEOUT_EN
         wait_cnt_reg  <= wait_cnt_next;
`endif
      end
   end

   assign PSEL      = psel_reg;
   assign PENABLE   = penable_reg;
   assign PADDR     = paddr_reg;
   assign PWRITE    = pwrite_reg;
   assign PWDATA    = pwdata_reg;
   assign PSTRB     = pstrb_reg;
   assign PPROT     = pprot_reg;
   assign rsp_valid = rsp_valid_reg;
   assign rsp_rdata = rsp_rdata_reg;
   assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_apb4_req_arbiter.sv
// Testbench for apb4_req_arbiter: scenario tasks with a response scoreboard
// and a simple APB slave model with programmable wait states.
module tb_apb4_req_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int TO = 16;

   logic              PCLK = 1'b0;
   logic              PRESETn;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [N*AW-1:0]   req_addr;
   logic [N-1:0]      req_write;
   logic [N*DW-1:0]   req_wdata;
   logic [N*SW-1:0]   req_strb;
   logic [N*3-1:0]    req_prot;
   logic [N-1:0]      rsp_valid;
   logic [DW-1:0]     rsp_rdata;
   logic              rsp_err;
   logic              PSEL, PENABLE, PWRITE;
   logic [AW-1:0]     PADDR;
   logic [DW-1:0]     PWDATA;
   logic [SW-1:0]     PSTRB;
   logic [2:0]        PPROT;
   logic [DW-1:0]     PRDATA  = '0;
   logic              PREADY  = 1'b0;
   logic              PSLVERR = 1'b0;

   typedef struct {
      int            idx;
      logic [DW-1:0] rdata;
      logic          err;
   } exp_t;

   exp_t          sb[$];
   int            checks = 0;
   int            errors = 0;
   int            slave_wait = 0;
   logic [DW-1:0] slave_rdata = '0;
   logic          slave_err = 1'b0;
   int            acc_cnt = 0;

   apb4_req_arbiter #(
      .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
      .req_prot(req_prot), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR),
      .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   // Slave model: PREADY low for slave_wait ACCESS cycles, then high; high
   // outside ACCESS so the DUT must ignore it there.
   always begin
      @(posedge PCLK);
      #2;
      if (PSEL && PENABLE) begin
         PREADY = (acc_cnt >= slave_wait);
         acc_cnt++;
      end else begin
         PREADY  = 1'b1;
         acc_cnt = 0;
      end
      PRDATA  = slave_rdata;
      PSLVERR = slave_err;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [SW-1:0] s, input logic [2:0] p);
      req_write[i]           = wr;
      req_addr[i*AW +: AW]   = a;
      req_wdata[i*DW +: DW]  = d;
      req_strb[i*SW +: SW]   = s;
      req_prot[i*3 +: 3]     = p;
      req_valid[i]           = 1'b1;
   endtask

   task automatic do_reset();
      PRESETn = 1'b0;
      tick();
      tick();
      PRESETn = 1'b1;
   endtask

   task automatic test_reset();
      req_valid = '0;
      PRESETn   = 1'b0;
      tick();
      tick();
      checks++; if (PSEL !== 1'b0) begin errors++; $display("FAIL reset_psel: got %b expected 0", PSEL); end
      checks++; if (PENABLE !== 1'b0) begin errors++; $display("FAIL reset_penable: got %b expected 0", PENABLE); end
      checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
      checks++; if (PADDR !== '0 || PSTRB !== '0 || rsp_err !== 1'b0) begin
         errors++; $display("FAIL reset_outputs: paddr %h pstrb %h rsp_err %b expected all 0", PADDR, PSTRB, rsp_err);
      end
      req_valid = 4'b0001;
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
      req_valid = '0;
      PRESETn   = 1'b1;
      tick();
      $display("reset: done");
   endtask

   task automatic test_write_basic();
      exp_t e;
      slave_wait = 0;
      slave_err  = 1'b0;
      set_req(0, 1'b1, 32'h10, 32'hA5A5A5A5, 4'hF, 3'b010);
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL basic_ready: got %b expected 0001", req_ready); end
      tick();
      req_valid = '0;
      sb.push_back('{0, '0, 1'b0});
      checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b0) begin errors++; $display("FAIL basic_setup: psel %b penable %b expected 1 0", PSEL, PENABLE); end
      checks++; if (PADDR !== 32'h10 || PWRITE !== 1'b1 || PWDATA !== 32'hA5A5A5A5 || PSTRB !== 4'hF || PPROT !== 3'b010) begin
         errors++; $display("FAIL basic_fields: addr %h wr %b data %h strb %h prot %b expected 10 1 a5a5a5a5 f 010", PADDR, PWRITE, PWDATA, PSTRB, PPROT);
      end
      tick();
      checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin errors++; $display("FAIL basic_access: psel %b penable %b expected 1 1", PSEL, PENABLE); end
      tick();
      e = sb.pop_front();
      checks++; if (rsp_valid !== (4'b1 << e.idx) || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
         errors++; $display("FAIL basic_rsp: valid %b rdata %h err %b expected %b %h %b", rsp_valid, rsp_rdata, rsp_err, 4'b1 << e.idx, e.rdata, e.err);
      end
      checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin errors++; $display("FAIL basic_release: psel %b penable %b expected 0 0", PSEL, PENABLE); end
      $display("write_basic: req 0 write addr 10 rsp %b err %b", rsp_valid, rsp_err);
   endtask

   task automatic test_read_wait();
      exp_t e;
      int   n_acc;
      slave_wait  = 2;
      slave_rdata = 32'h12345678;
      set_req(2, 1'b0, 32'h20, 32'hFFFFFFFF, 4'hF, 3'b000);
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL read_ready: got %b expected 0100", req_ready); end
      tick();
      req_valid = '0;
      sb.push_back('{2, 32'h12345678, 1'b0});
      checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b0 || PWRITE !== 1'b0 || PSTRB !== 4'h0 || PADDR !== 32'h20) begin
         errors++; $display("FAIL read_setup: psel %b pen %b wr %b strb %h addr %h expected 1 0 0 0 20", PSEL, PENABLE, PWRITE, PSTRB, PADDR);
      end
      n_acc = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (!(PSEL && PENABLE)) break;
         n_acc++;
         checks++; if (PADDR !== 32'h20 || PSTRB !== 4'h0 || req_ready !== 4'b0000) begin
            errors++; $display("FAIL read_stable: addr %h strb %h ready %b expected 20 0 0000", PADDR, PSTRB, req_ready);
         end
      end
      checks++; if (n_acc !== 3) begin errors++; $display("FAIL read_access_len: got %0d expected 3", n_acc); end
      e = sb.pop_front();
      checks++; if (rsp_valid !== (4'b1 << e.idx) || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
         errors++; $display("FAIL read_rsp: valid %b rdata %h err %b expected %b %h %b", rsp_valid, rsp_rdata, rsp_err, 4'b1 << e.idx, e.rdata, e.err);
      end
      slave_wait = 0;
      $display("read_wait: req 2 read addr 20 access %0d cycles rdata %h", n_acc, rsp_rdata);
   endtask

   task automatic test_round_robin();
      int   exp_order[5] = '{0, 1, 2, 3, 0};
      int   grants, rsps, cur;
      bit   drop_pending;
      exp_t e;
      do_reset();
      slave_wait  = 0;
      slave_rdata = 32'hCAFE0000;
      for (int i = 0; i < N; i++)
         set_req(i, (i % 2) == 0, 32'h100 + 32'(i * 4), 32'h1000 + 32'(i), 4'hF, 3'(i));
      #1;
      grants = 0; rsps = 0; cur = 0; drop_pending = 1'b0;
      for (int cyc = 0; cyc < 60 && (grants < 5 || rsps < 5); cyc++) begin
         if (drop_pending) begin
            req_valid = '0;
            drop_pending = 1'b0;
            #1;
         end
         if (rsp_valid !== 4'b0000) begin
            rsps++;
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL rr_rsp: got %b expected no response", rsp_valid);
            end else begin
               e = sb.pop_front();
               if (rsp_valid !== (4'b1 << e.idx) || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                  errors++; $display("FAIL rr_rsp: valid %b rdata %h err %b expected %b %h %b", rsp_valid, rsp_rdata, rsp_err, 4'b1 << e.idx, e.rdata, e.err);
               end
            end
         end
         if (PSEL) begin
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rr_ready_busy: got %b expected 0000", req_ready); end
            if (!PENABLE) begin
               checks++; if (PADDR !== 32'h100 + 32'(cur * 4)) begin errors++; $display("FAIL rr_addr: got %h expected %h", PADDR, 32'h100 + 32'(cur * 4)); end
            end
         end else if (req_ready !== 4'b0000 && grants < 5) begin
            cur = exp_order[grants];
            checks++; if (req_ready !== (4'b1 << cur)) begin errors++; $display("FAIL rr_order: grant %0d got %b expected %b", grants, req_ready, 4'b1 << cur); end
            $display("round_robin: grant %0d ready %b", grants, req_ready);
            sb.push_back('{cur, ((cur % 2) == 0) ? 32'h0 : 32'hCAFE0000, 1'b0});
            grants++;
            if (grants == 5) drop_pending = 1'b1;
         end
         tick();
      end
      checks++; if (grants !== 5 || rsps !== 5) begin errors++; $display("FAIL rr_count: grants %0d rsps %0d expected 5 5", grants, rsps); end
      req_valid = '0;
   endtask

   task automatic test_slverr();
      exp_t e;
      slave_err = 1'b1;
      set_req(1, 1'b1, 32'h40, 32'hDEADBEEF, 4'h3, 3'b001);
      #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL slverr_ready: got %b expected 0010", req_ready); end
      tick();
      req_valid = '0;
      sb.push_back('{1, '0, 1'b1});
      for (int c = 0; c < 10; c++) begin
         tick();
         if (rsp_valid !== 4'b0000) break;
      end
      e = sb.pop_front();
      checks++; if (rsp_valid !== (4'b1 << e.idx) || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
         errors++; $display("FAIL slverr_rsp: valid %b rdata %h err %b expected %b %h %b", rsp_valid, rsp_rdata, rsp_err, 4'b1 << e.idx, e.rdata, e.err);
      end
      slave_err = 1'b0;
      $display("slverr: req 1 write rsp %b err %b", rsp_valid, rsp_err);
      tick();
   endtask

   task automatic test_reset_in_access();
      exp_t e;
      slave_wait = 1000;
      set_req(1, 1'b1, 32'h80, 32'h55, 4'hF, 3'b000);
      #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rst_acc_ready: got %b expected 0010", req_ready); end
      tick();
      req_valid = '0;
      tick();
      checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin errors++; $display("FAIL rst_acc_access: psel %b pen %b expected 1 1", PSEL, PENABLE); end
      PRESETn = 1'b0;
      tick();
      PRESETn = 1'b1;
      checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0 || rsp_valid !== 4'b0000) begin
         errors++; $display("FAIL rst_acc_drop: psel %b pen %b rsp %b expected 0 0 0000", PSEL, PENABLE, rsp_valid);
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++; if (rsp_valid !== 4'b0000 || PSEL !== 1'b0) begin errors++; $display("FAIL rst_acc_quiet: rsp %b psel %b expected 0000 0", rsp_valid, PSEL); end
      end
      slave_wait = 0;
      set_req(0, 1'b0, 32'hC0, 32'h0, 4'hF, 3'b000);
      set_req(2, 1'b0, 32'hC8, 32'h0, 4'hF, 3'b000);
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_acc_regrant: got %b expected 0001", req_ready); end
      tick();
      req_valid = '0;
      sb.push_back('{0, 32'hCAFE0000, 1'b0});
      for (int c = 0; c < 10; c++) begin
         tick();
         if (rsp_valid !== 4'b0000) break;
      end
      e = sb.pop_front();
      checks++; if (rsp_valid !== (4'b1 << e.idx) || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
         errors++; $display("FAIL rst_acc_rsp: valid %b rdata %h err %b expected %b %h %b", rsp_valid, rsp_rdata, rsp_err, 4'b1 << e.idx, e.rdata, e.err);
      end
      $display("reset_in_access: regrant rsp %b rdata %h", rsp_valid, rsp_rdata);
      tick();
   endtask

`ifdef APB_TIMEOUT_EN
   task automatic test_timeout();
      exp_t e;
      int   n_acc;
      slave_wait  = 1000;
      slave_rdata = 32'h77777777;
      set_req(0, 1'b0, 32'hE0, 32'h0, 4'hF, 3'b000);
      #1;
      tick();
      req_valid = '0;
      sb.push_back('{0, '0, 1'b1});
      n_acc = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (!(PSEL && PENABLE)) break;
         n_acc++;
      end
      checks++; if (n_acc !== TO) begin errors++; $display("FAIL timeout_len: got %0d expected %0d", n_acc, TO); end
      e = sb.pop_front();
      checks++; if (rsp_valid !== (4'b1 << e.idx) || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
         errors++; $display("FAIL timeout_rsp: valid %b rdata %h err %b expected %b %h %b", rsp_valid, rsp_rdata, rsp_err, 4'b1 << e.idx, e.rdata, e.err);
      end
      slave_wait = 0;
      $display("timeout: access %0d cycles rsp %b err %b", n_acc, rsp_valid, rsp_err);
   endtask
`endif

   initial begin
      PRESETn   = 1'b0;
      req_valid = '0;
      req_write = '0;
      req_addr  = '0;
      req_wdata = '0;
      req_strb  = '0;
      req_prot  = '0;
      test_reset();
      test_write_basic();
      test_read_wait();
      test_round_robin();
      test_slverr();
      test_reset_in_access();
`ifdef APB_TIMEOUT_EN
      test_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
